// File: rtl/equeuels_dis.sv
// Load/store issue queue with CDB operand capture and address disambiguation; build with EQUEUELS_FLUSH_EN for a flush input.
// Latency: an op with ready operands issues the cycle after dispatch or after the CDB broadcast that wakes it.
// Backpressure: dispatch_ready drops when full unless the selected op retires the same edge; issuels_done holds selection.
module equeuels_dis #(
    parameter int DEPTH  = 8,
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32,
    parameter int OFF_W  = 16
) (
    input  logic                        clk,
    input  logic                        reset,
`ifdef EQUEUELS_FLUSH_EN
    input  logic                        flush,
`endif
    input  logic                        dispatch_opcode,
    input  logic [OFF_W-1:0]            dispatch_offset,
    input  logic [TAG_W-1:0]            dispatch_rdtag,
    input  logic [TAG_W-1:0]            dispatch_rstag,
    input  logic [TAG_W-1:0]            dispatch_rttag,
    input  logic [DATA_W-1:0]           dispatch_rsdata,
    input  logic [DATA_W-1:0]           dispatch_rtdata,
    input  logic                        dispatch_rsvalid,
    input  logic                        dispatch_rtvalid,
    input  logic                        dispatch_en,
    output logic                        dispatch_ready,
    input  logic [TAG_W-1:0]            cdb_tag,
    input  logic [DATA_W-1:0]           cdb_data,
    input  logic                        cdb_valid,
    output logic                        issuels_opcode,
    output logic [TAG_W-1:0]            issuels_rdtag,
    output logic [DATA_W-1:0]           issuels_addr,
    output logic [DATA_W-1:0]           issuels_data,
    output logic                        issuels_ready,
    input  logic                        issuels_done,
    output logic [$clog2(DEPTH+1)-1:0]  count
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic              vld;
        logic              op;
        logic [OFF_W-1:0]  off;
        logic [TAG_W-1:0]  rd;
        logic [TAG_W-1:0]  rs_tag;
        logic [TAG_W-1:0]  rt_tag;
        logic [DATA_W-1:0] rs_dat;
        logic              rs_ok;
        logic [DATA_W-1:0] rt_dat;
        logic              rt_ok;
        logic [DATA_W-1:0] addr;
    } ent_t;

    function automatic logic [DATA_W-1:0] sext(input logic [OFF_W-1:0] off);
        return {{(DATA_W-OFF_W){off[OFF_W-1]}}, off};
    endfunction

    ent_t             ent_q  [DEPTH];
    ent_t             ent_d  [DEPTH];
    ent_t             ent_c  [DEPTH];
    ent_t             ent_up [DEPTH];
    ent_t             ent_new;
    logic [DEPTH-1:0] elig;
    logic             any_elig;
    logic [IW-1:0]    sel;
    logic             flush_w;
    logic             remove;
    logic             accept;
    logic [CW-1:0]    tail;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;

`ifdef EQUEUELS_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
            count_q <= count_d;
        end
    end

    // CDB capture applied to resident entries; selection still looks at ent_q.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_c[i] = ent_q[i];
            if (cdb_valid && ent_q[i].vld) begin
                if (!ent_q[i].rs_ok && ent_q[i].rs_tag == cdb_tag) begin
                    ent_c[i].rs_dat = cdb_data;
                    ent_c[i].rs_ok  = 1'b1;
                    ent_c[i].addr   = cdb_data + sext(ent_q[i].off);
                end
                if (!ent_q[i].rt_ok && ent_q[i].rt_tag == cdb_tag) begin
                    ent_c[i].rt_dat = cdb_data;
                    ent_c[i].rt_ok  = 1'b1;
                end
            end
        end
    end

    // Stores issue only from the head; loads wait on any older store with unknown or aliasing word address.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            logic rdy;
            logic blk;
            rdy = ent_q[i].vld && ent_q[i].rs_ok && (ent_q[i].op || ent_q[i].rt_ok);
            blk = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                if (j < i && ent_q[j].vld && !ent_q[j].op &&
                    (!ent_q[j].rs_ok || ent_q[j].addr[DATA_W-1:2] == ent_q[i].addr[DATA_W-1:2]))
                    blk = 1'b1;
            end
            elig[i] = rdy && (ent_q[i].op ? !blk : (i == 0));
        end
    end

    always_comb begin
        sel = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (elig[i]) sel = IW'(i);
        end
    end

    assign any_elig       = |elig;
    assign issuels_ready  = any_elig && !flush_w;
    assign dispatch_ready = !flush_w && ((count_q < CW'(DEPTH)) || (any_elig && issuels_done));
    assign remove         = issuels_ready && issuels_done;
    assign accept         = dispatch_en && dispatch_ready;
    assign tail           = remove ? (count_q - CW'(1)) : count_q;
    assign count          = count_q;

    always_comb begin
        issuels_opcode = 1'b0;
        issuels_rdtag  = '0;
        issuels_addr   = '0;
        issuels_data   = '0;
        if (issuels_ready) begin
            issuels_opcode = ent_q[sel].op;
            issuels_rdtag  = ent_q[sel].rd;
            issuels_addr   = ent_q[sel].addr;
            issuels_data   = ent_q[sel].rt_dat;
        end
    end

    // A broadcast in the dispatch cycle is folded into the new entry so it is never missed.
    always_comb begin
        ent_new        = '0;
        ent_new.vld    = 1'b1;
        ent_new.op     = dispatch_opcode;
        ent_new.off    = dispatch_offset;
        ent_new.rd     = dispatch_rdtag;
        ent_new.rs_tag = dispatch_rstag;
        ent_new.rt_tag = dispatch_rttag;
        ent_new.rs_dat = dispatch_rsdata;
        ent_new.rs_ok  = dispatch_rsvalid;
        ent_new.rt_dat = dispatch_rtdata;
        ent_new.rt_ok  = dispatch_rtvalid;
        if (!dispatch_rsvalid && cdb_valid && dispatch_rstag == cdb_tag) begin
            ent_new.rs_dat = cdb_data;
            ent_new.rs_ok  = 1'b1;
        end
        if (!dispatch_rtvalid && cdb_valid && dispatch_rttag == cdb_tag) begin
            ent_new.rt_dat = cdb_data;
            ent_new.rt_ok  = 1'b1;
        end
        ent_new.addr = ent_new.rs_dat + sext(dispatch_offset);
    end

    always_comb begin
        for (int i = 0; i < DEPTH-1; i++) ent_up[i] = ent_c[i+1];
        ent_up[DEPTH-1] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_c[i];
            if (remove && (IW'(i) >= sel)) ent_d[i] = ent_up[i];
            if (accept && (CW'(i) == tail)) ent_d[i] = ent_new;
            if (flush_w) ent_d[i] = '0;
        end
        count_d = count_q;
        if (accept && !remove) count_d = count_q + CW'(1);
        if (remove && !accept) count_d = count_q - CW'(1);
        if (flush_w) count_d = '0;
    end

endmodule

// File: tb/tb_equeuels_dis.sv
// Bench for equeuels_dis: table of per-cycle vectors plus hand sequences for full-queue and async reset cases.
// Issued ops are checked against a queue of expected issues filled as stimulus is applied.
module tb_equeuels_dis;
    logic        clk = 1'b0;
    logic        reset;
    logic        dispatch_opcode;
    logic [15:0] dispatch_offset;
    logic [5:0]  dispatch_rdtag, dispatch_rstag, dispatch_rttag;
    logic [31:0] dispatch_rsdata, dispatch_rtdata;
    logic        dispatch_rsvalid, dispatch_rtvalid, dispatch_en, dispatch_ready;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        cdb_valid;
    logic        issuels_opcode;
    logic [5:0]  issuels_rdtag;
    logic [31:0] issuels_addr, issuels_data;
    logic        issuels_ready, issuels_done;
    logic [3:0]  count;

    always #5 clk = ~clk;

    equeuels_dis #(.DEPTH(8), .TAG_W(6), .DATA_W(32), .OFF_W(16)) dut (
        .clk(clk), .reset(reset),
        .dispatch_opcode(dispatch_opcode), .dispatch_offset(dispatch_offset),
        .dispatch_rdtag(dispatch_rdtag), .dispatch_rstag(dispatch_rstag), .dispatch_rttag(dispatch_rttag),
        .dispatch_rsdata(dispatch_rsdata), .dispatch_rtdata(dispatch_rtdata),
        .dispatch_rsvalid(dispatch_rsvalid), .dispatch_rtvalid(dispatch_rtvalid),
        .dispatch_en(dispatch_en), .dispatch_ready(dispatch_ready),
        .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_valid(cdb_valid),
        .issuels_opcode(issuels_opcode), .issuels_rdtag(issuels_rdtag),
        .issuels_addr(issuels_addr), .issuels_data(issuels_data),
        .issuels_ready(issuels_ready), .issuels_done(issuels_done),
        .count(count)
    );

    typedef struct {
        string       nm;
        logic        en, op;
        logic [15:0] off;
        logic [5:0]  rd, rs, rt;
        logic [31:0] rsd, rtd;
        logic        rsv, rtv, cv;
        logic [5:0]  ct;
        logic [31:0] cd;
        logic        dn;
        logic        ei;
        logic [31:0] ea;
        logic [3:0]  ec;
        logic        ed;
        logic        sb;
        logic        sb_op;
        logic [5:0]  sb_rd;
        logic [31:0] sb_addr, sb_data;
    } vec_t;

    typedef struct {
        logic        op;
        logic [5:0]  rd;
        logic [31:0] addr, data;
    } iss_t;

    vec_t tab[$];
    iss_t sb_q[$];
    int   checks = 0;
    int   failures = 0;

    function automatic vec_t mk(string nm, int en, int op, int off, int rd, int rs, int rt,
                                int rsd, int rtd, int rsv, int rtv, int cv, int ct, int cd,
                                int dn, int ei, int ea, int ec, int ed);
        vec_t v;
        v.nm = nm; v.en = en[0]; v.op = op[0]; v.off = off[15:0];
        v.rd = rd[5:0]; v.rs = rs[5:0]; v.rt = rt[5:0];
        v.rsd = rsd; v.rtd = rtd; v.rsv = rsv[0]; v.rtv = rtv[0];
        v.cv = cv[0]; v.ct = ct[5:0]; v.cd = cd; v.dn = dn[0];
        v.ei = ei[0]; v.ea = ea; v.ec = ec[3:0]; v.ed = ed[0];
        v.sb = 1'b0; v.sb_op = 1'b0; v.sb_rd = '0; v.sb_addr = '0; v.sb_data = '0;
        return v;
    endfunction

    task automatic add_sb(input int op, input int rd, input int addr, input int data);
        tab[tab.size()-1].sb      = 1'b1;
        tab[tab.size()-1].sb_op   = op[0];
        tab[tab.size()-1].sb_rd   = rd[5:0];
        tab[tab.size()-1].sb_addr = addr;
        tab[tab.size()-1].sb_data = data;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        iss_t e;
        dispatch_en = v.en; dispatch_opcode = v.op; dispatch_offset = v.off;
        dispatch_rdtag = v.rd; dispatch_rstag = v.rs; dispatch_rttag = v.rt;
        dispatch_rsdata = v.rsd; dispatch_rtdata = v.rtd;
        dispatch_rsvalid = v.rsv; dispatch_rtvalid = v.rtv;
        cdb_valid = v.cv; cdb_tag = v.ct; cdb_data = v.cd;
        issuels_done = v.dn;
        #1;
        chk({v.nm, ".issuels_ready"}, 32'(issuels_ready), 32'(v.ei));
        chk({v.nm, ".issuels_addr"}, issuels_addr, v.ea);
        chk({v.nm, ".count"}, 32'(count), 32'(v.ec));
        chk({v.nm, ".dispatch_ready"}, 32'(dispatch_ready), 32'(v.ed));
        if (v.sb) sb_q.push_back('{v.sb_op, v.sb_rd, v.sb_addr, v.sb_data});
        if (issuels_ready && issuels_done) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL %s.unexpected_issue: got issue at addr %h, required none", v.nm, issuels_addr);
            end else begin
                e = sb_q.pop_front();
                chk({v.nm, ".iss_opcode"}, 32'(issuels_opcode), 32'(e.op));
                chk({v.nm, ".iss_rdtag"}, 32'(issuels_rdtag), 32'(e.rd));
                chk({v.nm, ".iss_addr"}, issuels_addr, e.addr);
                chk({v.nm, ".iss_data"}, issuels_data, e.data);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic mid_reset(input string nm);
        #2;
        reset = 1'b0;
        #1;
        chk({nm, ".count"}, 32'(count), 32'd0);
        chk({nm, ".issuels_ready"}, 32'(issuels_ready), 32'd0);
        chk({nm, ".dispatch_ready"}, 32'(dispatch_ready), 32'd1);
        chk({nm, ".issuels_addr"}, issuels_addr, 32'd0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        dispatch_en = 0; dispatch_opcode = 0; dispatch_offset = '0;
        dispatch_rdtag = '0; dispatch_rstag = '0; dispatch_rttag = '0;
        dispatch_rsdata = '0; dispatch_rtdata = '0;
        dispatch_rsvalid = 0; dispatch_rtvalid = 0;
        cdb_valid = 0; cdb_tag = '0; cdb_data = '0; issuels_done = 0;
        #2 reset = 1'b0;
        #2;
        chk("rst.count", 32'(count), 32'd0);
        chk("rst.issuels_ready", 32'(issuels_ready), 32'd0);
        chk("rst.dispatch_ready", 32'(dispatch_ready), 32'd1);
        chk("rst.issuels_opcode", 32'(issuels_opcode), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        //                  en op off    rd rs rt rsd      rtd   rsv rtv cv ct cd      dn ei ea      ec ed
        tab.push_back(mk("A0", 1, 0, 'h0,    0, 1, 2, 'h100,   0,    1, 0, 0, 0, 0,      0, 0, 0,     0, 1));
        tab.push_back(mk("A1", 1, 1, 'h4,    3, 1, 30,'h200,   0,    1, 0, 0, 0, 0,      0, 0, 0,     1, 1));
        add_sb(1, 3, 'h204, 0);
        tab.push_back(mk("A2", 0, 0, 0,      0, 0, 0, 0,       0,    0, 0, 0, 0, 0,      1, 1, 'h204, 2, 1));
        tab.push_back(mk("A3", 0, 0, 0,      0, 0, 0, 0,       0,    0, 0, 0, 0, 0,      0, 0, 0,     1, 1));
        tab.push_back(mk("A4", 0, 0, 0,      0, 0, 0, 0,       0,    0, 0, 1, 2, 'hAA,   0, 0, 0,     1, 1));
        add_sb(0, 0, 'h100, 'hAA);
        tab.push_back(mk("A5", 0, 0, 0,      0, 0, 0, 0,       0,    0, 0, 0, 0, 0,      1, 1, 'h100, 1, 1));
        tab.push_back(mk("A6", 0, 0, 0,      0, 0, 0, 0,       0,    0, 0, 0, 0, 0,      0, 0, 0,     0, 1));
        tab.push_back(mk("B0", 1, 0, 'h0,    0, 1, 5, 'h100,   0,    1, 0, 0, 0, 0,      0, 0, 0,     0, 1));
        tab.push_back(mk("B1", 1, 1, 'h2,    4, 1, 31,'h100,   0,    1, 0, 0, 0, 0,      0, 0, 0,     1, 1));
        tab.push_back(mk("B2", 0, 0, 0,      0, 0, 0, 0,       0,    0, 0, 0, 0, 0,      0, 0, 0,     2, 1));
        tab.push_back(mk("B3", 0, 0, 0,      0, 0, 0, 0,       0,    0, 0, 1, 5, 'hDEAD, 1, 0, 0,     2, 1));
        add_sb(0, 0, 'h100, 'hDEAD);
        tab.push_back(mk("B4", 0, 0, 0,      0, 0, 0, 0,       0,    0, 0, 0, 0, 0,      1, 1, 'h100, 2, 1));
        add_sb(1, 4, 'h102, 0);
        tab.push_back(mk("B5", 0, 0, 0,      0, 0, 0, 0,       0,    0, 0, 0, 0, 0,      1, 1, 'h102, 1, 1));
        tab.push_back(mk("B6", 0, 0, 0,      0, 0, 0, 0,       0,    0, 0, 0, 0, 0,      0, 0, 0,     0, 1));
        tab.push_back(mk("C0", 1, 0, 'h10,   0, 7, 8, 0,       'h55, 0, 1, 0, 0, 0,      0, 0, 0,     0, 1));
        tab.push_back(mk("C1", 1, 1, 'h0,    6, 1, 32,'h400,   0,    1, 0, 0, 0, 0,      0, 0, 0,     1, 1));
        tab.push_back(mk("C2", 0, 0, 0,      0, 0, 0, 0,       0,    0, 0, 0, 0, 0,      0, 0, 0,     2, 1));
        tab.push_back(mk("C3", 0, 0, 0,      0, 0, 0, 0,       0,    0, 0, 1, 7, 'h300,  0, 0, 0,     2, 1));
        add_sb(0, 0, 'h310, 'h55);
        tab.push_back(mk("C4", 0, 0, 0,      0, 0, 0, 0,       0,    0, 0, 0, 0, 0,      0, 1, 'h310, 2, 1));
        add_sb(1, 6, 'h400, 0);
        tab.push_back(mk("C5", 0, 0, 0,      0, 0, 0, 0,       0,    0, 0, 0, 0, 0,      1, 1, 'h310, 2, 1));
        tab.push_back(mk("C6", 0, 0, 0,      0, 0, 0, 0,       0,    0, 0, 0, 0, 0,      1, 1, 'h400, 1, 1));
        tab.push_back(mk("C7", 0, 0, 0,      0, 0, 0, 0,       0,    0, 0, 0, 0, 0,      0, 0, 0,     0, 1));
        tab.push_back(mk("F0", 1, 1, 'hFFFC, 12,9, 33,0,       0,    0, 0, 1, 9, 'h1000, 0, 0, 0,     0, 1));
        add_sb(1, 12, 'hFFC, 0);
        tab.push_back(mk("F1", 0, 0, 0,      0, 0, 0, 0,       0,    0, 0, 0, 0, 0,      1, 1, 'hFFC, 1, 1));
        tab.push_back(mk("F2", 0, 0, 0,      0, 0, 0, 0,       0,    0, 0, 0, 0, 0,      0, 0, 0,     0, 1));

        foreach (tab[k]) apply(tab[k]);

        // Full queue: one ready load at the head, seven stores waiting on rt tag 20.
        for (int i = 0; i < 8; i++) begin
            apply(mk($sformatf("D%0d", i), 1, (i == 0) ? 1 : 0, 0, (i == 0) ? 10 : 0, 1, 20,
                     (i == 0) ? 'h1000 : ('h2000 + 16*i), 0, 1, 0, 0, 0, 0,
                     0, (i > 0) ? 1 : 0, (i > 0) ? 'h1000 : 0, i, 1));
        end
        tab.delete();
        tab.push_back(mk("D8_issue_and_dispatch", 1, 0, 0, 0, 1, 20, 'h3000, 0, 1, 0, 0, 0, 0, 1, 1, 'h1000, 8, 1));
        add_sb(1, 10, 'h1000, 0);
        tab.push_back(mk("D9_full_drop", 1, 1, 0, 11, 1, 34, 'h5000, 0, 1, 0, 0, 0, 0, 0, 0, 0, 8, 0));
        tab.push_back(mk("D10_after_drop", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8, 0));
        foreach (tab[k]) apply(tab[k]);
        mid_reset("R_full");

        for (int k = 0; k < 3; k++) begin
            apply(mk($sformatf("L%0d", k), 1, 1, 0, k + 1, 1, 35, 16*(k + 1), 0, 1, 0, 0, 0, 0,
                     0, (k > 0) ? 1 : 0, (k > 0) ? 'h10 : 0, k, 1));
        end
        mid_reset("R_three");

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/equeuels_dis.md
Name: equeuels_dis

Overview:
- Parametrised successor of the load/store issue queue.
- Holds up to DEPTH memory ops in age order (entry 0 oldest) and captures operands broadcast on the CDB.
- Issues one op per cycle to the LS unit with address-based memory disambiguation: loads may bypass older loads, and may bypass older stores whose addresses are known and differ. Replaces the strict-FIFO policy.
- Sits between dispatch and the load/store execution unit.

Parameters:
- DEPTH, 8, number of queue entries (>=2).
- TAG_W, 6, physical register tag width.
- DATA_W, 32, data and address width.
- OFF_W, 16, immediate offset width; sign-extended to DATA_W.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- dispatch_opcode  in  1  1=load, 0=store.
- dispatch_offset  in  OFF_W  immediate offset.
- dispatch_rdtag  in  TAG_W  destination tag (loads).
- dispatch_rstag / dispatch_rttag  in  TAG_W  base / store-data source tags.
- dispatch_rsdata / dispatch_rtdata  in  DATA_W  operand values.
- dispatch_rsvalid / dispatch_rtvalid  in  1  operand value valid.
- dispatch_en  in  1  dispatch request.
- dispatch_ready  out  1  queue can accept this cycle.
- cdb_tag  in  TAG_W  CDB broadcast tag.
- cdb_data  in  DATA_W  CDB broadcast data.
- cdb_valid  in  1  CDB broadcast valid.
- issuels_opcode  out  1  selected op type.
- issuels_rdtag  out  TAG_W  selected op destination tag.
- issuels_addr  out  DATA_W  selected op effective address.
- issuels_data  out  DATA_W  selected op store data.
- issuels_ready  out  1  an entry is selected for issue.
- issuels_done  in  1  LS unit accepts the selected op.
- count  out  $clog2(DEPTH+1)  occupied entries.

Behaviour:
- Reset (reset=0, async): all entries invalid, count=0, issuels_ready=0, issuels_* fields=0, dispatch_ready=1.
- Entry state: valid, opcode, offset, rdtag, rstag, rttag, rsdata/rsvalid, rtdata/rtvalid, addr.
- addr = rsdata + sext(offset), computed when rs becomes valid: at dispatch, or on CDB capture as cdb_data + sext(offset).
- CDB capture: for every valid entry with rsvalid=0 and rstag==cdb_tag while cdb_valid=1, set rsdata=cdb_data, rsvalid=1, update addr. Same rule for rt. A matching tag on an already-valid operand is ignored.
- A dispatch in the same cycle as a matching CDB broadcast stores the CDB value (bypass); it is never lost.
- Ready: load needs rsvalid; store needs rsvalid and rtvalid.
- Selection (combinational, oldest-first priority): entry i is eligible when valid and ready, plus:
  - Store: no valid entry older than i exists, i.e. it is entry 0.
  - Load: every older store has rsvalid=1 and addr[DATA_W-1:2] differs from this load's addr[DATA_W-1:2]. Older loads never block.
- issuels_ready=1 when any entry is eligible. issuels_* carry the oldest eligible entry; fields are 0 when issuels_ready=0.
- Removal: selected entry is removed at the clock edge when issuels_ready & issuels_done. Younger entries collapse down one position the same edge, preserving age order.
- issuels_done while issuels_ready=0 is ignored.
- Dispatch: accepted when dispatch_en & dispatch_ready and written at the tail (index count, or count-1 if a removal happens the same edge).
- dispatch_ready = (count<DEPTH) | (issuels_ready & issuels_done).
- Full queue plus simultaneous issue and dispatch: both occur; count stays DEPTH.
- count: +1 on accept, -1 on removal, unchanged when both happen.
- dispatch_en while dispatch_ready=0: dropped, no state change.
- Latency: a dispatched op with ready operands can issue the cycle after dispatch. A CDB-woken op can issue the cycle after the broadcast.

Optional Feature:
- Macro EQUEUELS_FLUSH_EN.
- Defined: adds input flush (1 bit). flush=1 at a clock edge invalidates all entries and sets count=0. Any dispatch or removal that cycle is discarded. During flush, issuels_ready is forced to 0 and dispatch_ready to 0.
- Not defined: no flush port; queue clears only via reset.

Test Plan:
- Reset mid-operation: fill 3 entries, drop reset to 0 between clock edges -> count=0, issuels_ready=0, dispatch_ready=1 immediately, without waiting for a clock edge.
- Load bypass: store (rsvalid=1, rsdata=0x100, offset=0, rtvalid=0) then load (rsdata=0x200, offset=4) -> issuels_ready=1, addr=0x204, opcode=1. Load removed on done; store remains, count=1.
- Alias block: store addr 0x100 (rt pending), then load addr 0x102 -> issuels_ready=0. CDB rt tag 5 data 0xDEAD -> store issues with data=0xDEAD, then load issues next.
- Unknown store address: store rstag=7 pending, then load ready -> load blocked. CDB tag 7 data 0x300, offset 0x10 -> store addr=0x310; load becomes eligible.
- Full queue: DEPTH=8 entries with one eligible, dispatch_en=1 and issuels_done=1 same cycle -> dispatch accepted, count stays 8. Next cycle with no eligible entry -> dispatch_ready=0 and dispatch_en is dropped.
- CDB/dispatch collision: dispatch a load with rsvalid=0, rstag=9, offset=0xFFFC while cdb tag 9 data 0x1000 -> entry rsvalid=1, addr=0xFFC, issues next cycle.
